// File: rtl/iomem_timer_pkg.sv
// Shared constants and helpers for the iomem timer peripheral: register map,
// CTRL bit positions, channel stride and a byte-strobe merge function.
package iomem_timer_pkg;

  localparam logic [2:0] REG_CTRL  = 3'd0;
  localparam logic [2:0] REG_PRESC = 3'd1;
  localparam logic [2:0] REG_LOAD  = 3'd2;
  localparam logic [2:0] REG_COUNT = 3'd3;
  localparam logic [2:0] REG_STAT  = 3'd4;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IRQEN   = 2;

  localparam int CHAN_STRIDE = 32'h20;
  localparam int CHAN_SHIFT  = $clog2(CHAN_STRIDE);

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/iomem_timer_chan.sv
// One timer channel: CTRL/PRESC/LOAD/COUNT/STAT registers, prescaler,
// down-counter with periodic/one-shot reload, and a registered irq.
module iomem_timer_chan
  import iomem_timer_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_en_i,
  input  logic [2:0]  reg_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  logic        en_q, en_d, oneshot_q, oneshot_d, irqen_q, irqen_d;
  logic [15:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic [31:0] load_q, load_d, count_q, count_d;
  logic        exp_q, exp_d, irq_q;
  logic [31:0] wmerge;
  logic        ctrl_wr, presc_wr, load_wr, count_wr, stat_wr;
  logic        tick, cnt_tick, expire;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rdata_o = '0;
    case (reg_i)
      REG_CTRL:  rdata_o = {29'b0, irqen_q, oneshot_q, en_q};
      REG_PRESC: rdata_o = {16'b0, presc_q};
      REG_LOAD:  rdata_o = load_q;
      REG_COUNT: rdata_o = count_q;
      REG_STAT:  rdata_o = {31'b0, exp_q};
      default:   rdata_o = '0;
    endcase
  end

  assign wmerge   = apply_wstrb(rdata_o, wdata_i, wstrb_i);
  assign ctrl_wr  = wr_en_i && (reg_i == REG_CTRL);
  assign presc_wr = wr_en_i && (reg_i == REG_PRESC);
  assign load_wr  = wr_en_i && (reg_i == REG_LOAD);
  assign count_wr = wr_en_i && (reg_i == REG_COUNT);
  assign stat_wr  = wr_en_i && (reg_i == REG_STAT);

  // A CTRL write that clears EN kills the tick; a COUNT write drops its counter effect.
  assign tick     = en_q && (pcnt_q == presc_q) && !(ctrl_wr && !wmerge[CTRL_EN]);
  assign cnt_tick = tick && !count_wr;
  assign expire   = cnt_tick && (count_q == '0);

  always_comb begin
    en_d      = en_q;
    oneshot_d = oneshot_q;
    irqen_d   = irqen_q;
    presc_d   = presc_q;
    load_d    = load_q;
    count_d   = count_q;
    exp_d     = exp_q;
    pcnt_d    = pcnt_q + 16'd1;

    if (ctrl_wr || !en_q || (pcnt_q == presc_q)) pcnt_d = '0;

    if (expire && oneshot_q) en_d = 1'b0;
    if (ctrl_wr) begin
      en_d      = wmerge[CTRL_EN];
      oneshot_d = wmerge[CTRL_ONESHOT];
      irqen_d   = wmerge[CTRL_IRQEN];
    end

    if (presc_wr) presc_d = wmerge[15:0];
    if (load_wr)  load_d  = wmerge;

    if (count_wr)
      count_d = wmerge;
    else if (cnt_tick)
      count_d = (count_q != '0) ? count_q - 32'd1 : (oneshot_q ? '0 : load_q);

    if (stat_wr && wstrb_i[0] && wdata_i[0]) exp_d = 1'b0;
    if (expire) exp_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      irqen_q   <= 1'b0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      load_q    <= '0;
      count_q   <= '0;
      exp_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      irqen_q   <= irqen_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      load_q    <= load_d;
      count_q   <= count_d;
      exp_q     <= exp_d;
      irq_q     <= exp_q & irqen_q;
    end
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/iomem_timer.sv
// Multi-channel timer on the SoC iomem bus: window decode, one-cycle ack,
// registered read data and per-channel instances.
module iomem_timer
  import iomem_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int          NCH       = 2
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           iomem_valid,
  output logic           iomem_ready,
  input  logic [3:0]     iomem_wstrb,
  input  logic [31:0]    iomem_addr,
  input  logic [31:0]    iomem_wdata,
  output logic [31:0]    iomem_rdata,
  output logic [NCH-1:0] irq
);

  logic        sel, access, mapped, we;
  logic [2:0]  ch, rsel;
  logic        ready_q;
  logic [31:0] rdata_q, rd_mux;
  logic [31:0] chan_rdata [NCH];
  logic        unused_addr;

  assign sel    = iomem_valid && (iomem_addr[31:12] == BASE_ADDR[31:12]);
  assign ch     = iomem_addr[CHAN_SHIFT+2:CHAN_SHIFT];
  assign rsel   = iomem_addr[4:2];
  assign mapped = ({1'b0, ch} < 4'(NCH)) && (rsel <= REG_STAT);
  // Unmapped offsets are still acked; they just never reach a channel.
  assign access = sel && !ready_q;
  assign we     = access && (iomem_wstrb != 4'b0) && mapped;
  assign unused_addr = ^{iomem_addr[11:8], iomem_addr[1:0]};

  always_comb begin
    rd_mux = '0;
    if (mapped)
      for (int i = 0; i < NCH; i++)
        if (ch == 3'(i)) rd_mux = chan_rdata[i];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= access;
      rdata_q <= (access && (iomem_wstrb == 4'b0)) ? rd_mux : '0;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    iomem_timer_chan u_chan (
      .clk     (clk),
      .resetn  (resetn),
      .wr_en_i (we && (ch == 3'(i))),
      .reg_i   (rsel),
      .wdata_i (iomem_wdata),
      .wstrb_i (iomem_wstrb),
      .rdata_o (chan_rdata[i]),
      .irq_o   (irq[i])
    );
  end

endmodule
